// File: rtl/multiplexer_pkg.sv
// multiplexer_pkg: shared mode encodings for the round-robin multiplexer
package multiplexer_pkg;
  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;
endpackage

// File: rtl/multiplexer_rr_arbiter.sv
// rr_arbiter: combinational round-robin grant search starting at a pointer
module rr_arbiter #(
  parameter int CHANNELS = 4,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] i_req,
  input  logic [SEL_W-1:0]    i_ptr,
  output logic [CHANNELS-1:0] o_grant,
  output logic [SEL_W-1:0]    o_idx,
  output logic                o_any
);
  function automatic logic [SEL_W-1:0] wrap(input logic [SEL_W-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    return SEL_W'(s >= CHANNELS ? s - CHANNELS : s);
  endfunction
  // scan from the farthest offset back to ptr so the nearest requester wins
  always_comb begin
    o_any = 1'b0;
    o_idx = '0;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      if (i_req[wrap(i_ptr, k)]) begin
        o_any = 1'b1;
        o_idx = wrap(i_ptr, k);
      end
    end
    o_grant = o_any ? CHANNELS'(1) << o_idx : '0;
  end
endmodule

// File: rtl/multiplexer_rr.sv
// multiplexer_rr: registered N-channel valid/ready mux with fixed or round-robin select
module multiplexer_rr
  import multiplexer_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          Select,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_channel,
  output logic                      out_valid,
  input  logic                      out_ready
);
  logic [SEL_W-1:0]    r_ptr;
  logic [CHANNELS-1:0] w_rr_grant;
  logic [SEL_W-1:0]    w_rr_idx;
  logic                w_rr_any;
  logic                w_fix_any;
  logic                w_any;
  logic [SEL_W-1:0]    w_idx;
  logic                w_accept;
  logic                w_xfer;
  logic [WIDTH-1:0]    w_data;

  rr_arbiter #(.CHANNELS(CHANNELS), .SEL_W(SEL_W)) u_arb (
    .i_req   (in_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_rr_grant),
    .o_idx   (w_rr_idx),
    .o_any   (w_rr_any)
  );

  // grant mux, accept and handshake; reset blocks any transfer so nothing is taken during it
  always_comb begin
    w_fix_any = (int'(Select) < CHANNELS) && in_valid[Select];
    w_any     = mode == MODE_RR ? w_rr_any : w_fix_any;
    w_idx     = mode == MODE_RR ? w_rr_idx : Select;
    w_accept  = !reset && (!out_valid || out_ready);
    w_xfer    = w_any && w_accept;
    w_data    = in_data[w_idx*WIDTH +: WIDTH];
    in_ready  = !w_accept ? '0 : mode == MODE_RR ? w_rr_grant : w_fix_any ? CHANNELS'(1) << Select : '0;
  end

  // output register and pointer; a stall holds everything, only RR transfers move the pointer
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_channel <= '0;
      r_ptr       <= '0;
    end else if (w_accept) begin
      out_valid <= w_xfer;
      if (w_xfer) begin
        out_data    <= w_data;
        out_channel <= w_idx;
      end
      if (w_xfer && mode == MODE_RR)
        r_ptr <= w_idx == SEL_W'(CHANNELS - 1) ? '0 : w_idx + 1'b1;
    end
  end
endmodule

// File: tb/tb_multiplexer_rr.sv
// tb_multiplexer_rr: directed scoreboard bench for the round-robin multiplexer
module tb_multiplexer_rr;
  import multiplexer_pkg::*;
  typedef struct packed {logic [1:0] ch; logic [7:0] d;} ent_t;
  logic       clk = 1'b0;
  logic       reset;
  logic       mode;
  logic [1:0] Select;
  logic [7:0] dat [4];
  logic [31:0] in_data;
  logic [3:0] in_valid;
  logic [3:0] in_ready;
  logic [7:0] out_data;
  logic [1:0] out_channel;
  logic       out_valid;
  logic       out_ready;
  int         tests = 0;
  int         fails = 0;
  ent_t       sb [$];

  assign in_data = {dat[3], dat[2], dat[1], dat[0]};
  always #5 clk = ~clk;

  multiplexer_rr #(.WIDTH(8), .CHANNELS(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .mode        (mode),
    .Select      (Select),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_data    (out_data),
    .out_channel (out_channel),
    .out_valid   (out_valid),
    .out_ready   (out_ready)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input bit word, input int ch, input string tag);
    ent_t e;
    if (word) sb.push_back({2'(ch), dat[ch]});
    @(posedge clk);
    #1;
    if (word) begin
      e = sb.pop_front();
      chk({tag, "_valid"}, 32'(out_valid), 1);
      chk({tag, "_chan"}, 32'(out_channel), 32'(e.ch));
      chk({tag, "_data"}, 32'(out_data), 32'(e.d));
    end else chk({tag, "_valid"}, 32'(out_valid), 0);
  endtask

  initial begin
    reset = 1'b1;
    mode = MODE_RR;
    Select = 2'd0;
    in_valid = 4'hF;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) dat[i] = 8'(8'hA0 + i);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_chan", 32'(out_channel), 0);
    chk("rst_ready", 32'(in_ready), 0);
    reset = 1'b0;
    #1;
    chk("rst_first_grant", 32'(in_ready), 32'h1);
    for (int i = 0; i < 8; i++) step(1'b1, i % 4, "rr_fair");
    in_valid = 4'b0010;
    step(1'b1, 1, "rr_setptr");
    in_valid = 4'b1010;
    #1;
    chk("rr_sparse_ready", 32'(in_ready), 32'h8);
    step(1'b1, 3, "rr_sparse0");
    step(1'b1, 1, "rr_sparse1");
    step(1'b1, 3, "rr_sparse2");
    mode = MODE_FIXED;
    Select = 2'd2;
    in_valid = 4'hF;
    dat[2] = 8'h5C;
    #1;
    chk("fix_ready", 32'(in_ready), 32'h4);
    step(1'b1, 2, "fix0");
    step(1'b1, 2, "fix1");
    in_valid = 4'b1011;
    #1;
    chk("fix_noready", 32'(in_ready), 0);
    step(1'b0, 0, "fix_drop");
    mode = MODE_RR;
    in_valid = 4'hF;
    step(1'b1, 0, "stall_fill");
    out_ready = 1'b0;
    #1;
    chk("stall_ready", 32'(in_ready), 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("stall_valid", 32'(out_valid), 1);
      chk("stall_chan", 32'(out_channel), 0);
      chk("stall_data", 32'(out_data), 32'hA0);
      chk("stall_ready_hold", 32'(in_ready), 0);
    end
    out_ready = 1'b1;
    #1;
    chk("release_ready", 32'(in_ready), 32'h2);
    step(1'b1, 1, "stall_release");
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("prerst_hold", 32'(out_channel), 1);
    reset = 1'b1;
    #1;
    chk("rst_stall_ready", 32'(in_ready), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_stall_valid", 32'(out_valid), 0);
    chk("rst_stall_chan", 32'(out_channel), 0);
    chk("rst_stall_data", 32'(out_data), 0);
    out_ready = 1'b1;
    #1;
    chk("rst_stall_ptr", 32'(in_ready), 32'h1);
    step(1'b1, 0, "post_rst");
    in_valid = 4'h0;
    step(1'b0, 0, "idle");
    chk("sb_empty", 32'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
